// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared widths and state type for the memory port arbiter
`ifndef PR_ADDR_W
`define PR_ADDR_W 6
`endif
`ifndef MEM_ADDR_W
`define MEM_ADDR_W 16
`endif
`ifndef MEM_DATA_W
`define MEM_DATA_W 8
`endif

package mem_port_arbiter_pkg;

  localparam int ARB_TAG_W  = `PR_ADDR_W;
  localparam int ARB_ADDR_W = `MEM_ADDR_W;
  localparam int ARB_DATA_W = `MEM_DATA_W;

  // One bus access at a time: either waiting for a winner or riding out the latency.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  // Counter width able to hold 0..max_val inclusive, never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_fetch_resp_buf.sv
// rtl/mem_port_arbiter_fetch_resp_buf.sv - one-entry valid/ready holding buffer for fetched bytes
module mem_port_arbiter_fetch_resp_buf #(
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  // Clear beats load so a redirect never lets a stale byte through; load beats pop.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares the single memory bus between instruction fetch and load/store
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ARB_ADDR_W,
  parameter int DATA_W       = ARB_DATA_W,
  parameter int TAG_W        = ARB_TAG_W,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic [ADDR_W-1:0] i_fetch_addr,
  input  logic              i_fetch_req_valid,
  output logic              o_fetch_req_ready,
  output logic [DATA_W-1:0] o_fetch_data,
  output logic              o_fetch_data_valid,
  input  logic              i_fetch_data_ready,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  input  logic              i_mem_we,
  input  logic [TAG_W-1:0]  i_mem_tag,
  input  logic              i_mem_req_valid,
  output logic              o_mem_req_ready,
  output logic [DATA_W-1:0] o_mem_resp_data,
  output logic [TAG_W-1:0]  o_mem_resp_tag,
  output logic              o_mem_resp_valid,
  output logic              o_bus_en,
  output logic              o_bus_we,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [DATA_W-1:0] o_bus_wdata,
  input  logic [DATA_W-1:0] i_bus_rdata
);

  localparam int LAT_W    = cnt_width(MEM_LATENCY);
  localparam int STARVE_W = cnt_width(STARVE_LIMIT);

  arb_state_e          r_state;
  arb_state_e          w_state_nxt;
  logic [LAT_W-1:0]    r_lat_cnt;
  logic [STARVE_W-1:0] r_starve;
  logic                r_drop;
  logic                r_is_fetch;
  logic                r_is_store;
  logic [TAG_W-1:0]    r_tag;

  logic                r_bus_en;
  logic                r_bus_we;
  logic [ADDR_W-1:0]   r_bus_addr;
  logic [DATA_W-1:0]   r_bus_wdata;

  logic                r_resp_valid;
  logic [DATA_W-1:0]   r_resp_data;
  logic [TAG_W-1:0]    r_resp_tag;

  logic                w_buf_valid;
  logic                w_fetch_elig;
  logic                w_starved;
  logic                w_mem_win;
  logic                w_fetch_win;
  logic                w_mem_grant;
  logic                w_fetch_grant;
  logic                w_grant;
  logic                w_lat_done;
  logic                w_buf_load;

  // Fetch may only compete while its buffer has room and no redirect is underway.
  assign w_fetch_elig = i_fetch_req_valid & ~w_buf_valid & ~i_flush;
  assign w_starved    = w_fetch_elig & (r_starve == STARVE_W'(STARVE_LIMIT));
  assign w_mem_win    = i_mem_req_valid & ~w_starved;
  assign w_fetch_win  = ~w_mem_win & w_fetch_elig;
  assign w_grant      = w_mem_grant | w_fetch_grant;

  // Next-state and grant decode; grants exist only in IDLE and never while reset is held.
  always_comb begin
    w_state_nxt   = r_state;
    w_mem_grant   = 1'b0;
    w_fetch_grant = 1'b0;
    w_lat_done    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!i_rst) begin
          w_mem_grant   = w_mem_win;
          w_fetch_grant = w_fetch_win;
          if (w_mem_win || w_fetch_win) begin
            w_state_nxt = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (r_lat_cnt == LAT_W'(MEM_LATENCY)) begin
          w_lat_done  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Counts the bus_en cycle plus MEM_LATENCY wait cycles; read data is taken on the last one.
  always_ff @(posedge i_clk) begin
    if (i_rst || w_grant || w_lat_done) begin
      r_lat_cnt <= '0;
    end else if (r_state == ST_BUSY) begin
      r_lat_cnt <= r_lat_cnt + LAT_W'(1);
    end
  end

  // Remember who owns the in-flight access so the response can be routed.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_is_fetch <= 1'b0;
      r_is_store <= 1'b0;
      r_tag      <= '0;
    end else if (w_grant) begin
      r_is_fetch <= w_fetch_grant;
      r_is_store <= w_mem_grant & i_mem_we;
      r_tag      <= i_mem_tag;
    end
  end

  // Bus strobe and payload are driven only in the cycle after the handshake.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bus_en    <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
    end else begin
      r_bus_en    <= w_grant;
      r_bus_we    <= w_mem_grant & i_mem_we;
      r_bus_addr  <= w_fetch_grant ? i_fetch_addr :
                     (w_mem_grant ? i_mem_addr : '0);
      r_bus_wdata <= (w_mem_grant && i_mem_we) ? i_mem_wdata : '0;
    end
  end

  // Consecutive arbitrations a ready fetch has lost to mem; saturates so fetch eventually wins.
  always_ff @(posedge i_clk) begin
    if (i_rst || w_fetch_grant) begin
      r_starve <= '0;
    end else if (w_mem_grant && w_fetch_elig &&
                 (r_starve != STARVE_W'(STARVE_LIMIT))) begin
      r_starve <= r_starve + STARVE_W'(1);
    end
  end

  // A redirect during an in-flight fetch marks its eventual data as stale.
  always_ff @(posedge i_clk) begin
    if (i_rst || w_lat_done) begin
      r_drop <= 1'b0;
    end else if (i_flush && (r_state == ST_BUSY) && r_is_fetch) begin
      r_drop <= 1'b1;
    end
  end

  // Mem completion pulse; stores report zero data so the consumer never sees bus noise.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_tag   <= '0;
    end else begin
      r_resp_valid <= w_lat_done & ~r_is_fetch;
      if (w_lat_done && !r_is_fetch) begin
        r_resp_data <= r_is_store ? '0 : i_bus_rdata;
        r_resp_tag  <= r_tag;
      end
    end
  end

  // A flush on the sampling edge itself also kills the byte.
  assign w_buf_load = w_lat_done & r_is_fetch & ~r_drop & ~i_flush;

  mem_port_arbiter_fetch_resp_buf #(
    .DATA_W (DATA_W)
  ) u_fetch_buf (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (i_flush),
    .i_load  (w_buf_load),
    .i_data  (i_bus_rdata),
    .o_data  (o_fetch_data),
    .o_valid (w_buf_valid),
    .i_ready (i_fetch_data_ready)
  );

  assign o_fetch_data_valid = w_buf_valid;
  assign o_fetch_req_ready  = w_fetch_grant;
  assign o_mem_req_ready    = w_mem_grant;
  assign o_mem_resp_valid   = r_resp_valid;
  assign o_mem_resp_data    = r_resp_data;
  assign o_mem_resp_tag     = r_resp_tag;
  assign o_bus_en           = r_bus_en;
  assign o_bus_we           = r_bus_we;
  assign o_bus_addr         = r_bus_addr;
  assign o_bus_wdata        = r_bus_wdata;

endmodule
